sha256_msg_sched: RTL and testbench
===================================

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
- REQ-001 The block SHALL have no parameters; word width is fixed at 32 bits and round count at 64.
- REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge only.
- REQ-003 i_rst  input  1  reset, synchronous and active-high.
- REQ-004 i_start  input  1  one-cycle request to begin a new 512-bit block; honoured only in IDLE.
- REQ-005 i_wvalid  input  1  input message word valid.
- REQ-006 i_wdata  input  32  input message word, big-endian word order, M0 first.
- REQ-007 o_wready  output  1  block accepts an input word this cycle.
- REQ-008 o_tvalid  output  1  schedule word W_t valid.
- REQ-009 o_tdata  output  32  schedule word W_t.
- REQ-010 o_tidx  output  6  round index t of o_tdata, 0..63.
- REQ-011 i_tready  input  1  round logic accepts W_t this cycle.
- REQ-012 o_busy  output  1  high in LOAD or RUN.
- REQ-013 o_done  output  1  one-cycle pulse after W63 is accepted.

Function
- REQ-014 States SHALL be IDLE, LOAD, RUN; a 4-bit load counter and a 6-bit round counter SHALL be kept.
- REQ-015 IDLE: o_wready=0, o_tvalid=0; i_start=1 -> LOAD next cycle, load counter=0.
- REQ-016 LOAD: o_wready=1; each cycle with i_wvalid=1 SHALL write i_wdata into buffer slot w[load counter] and increment the counter.
- REQ-017 The 16th accepted word (counter=15) SHALL move to RUN next cycle with round counter=0; o_tvalid SHALL be 1 in the first RUN cycle (1-cycle latency).
- REQ-018 RUN: o_tvalid=1, o_tdata=w[0] (registered, no combinational path from inputs), o_tidx=round counter, o_wready=0.
- REQ-019 A transfer occurs when o_tvalid and i_tready are both 1; on transfer w[i]<=w[i+1] for i=0..14 and w[15]<=sigm1(w[14])+w[9]+sigm0(w[1])+w[0], sum modulo 2^32, and the round counter increments.
- REQ-020 sigm0(x)=ROTR7^ROTR18^SHR3; sigm1(x)=ROTR17^ROTR19^SHR10, per FIPS 180-4.
- REQ-021 While i_tready=0 in RUN, o_tdata, o_tidx and the buffer SHALL hold unchanged.
- REQ-022 Transfer at round counter=63 SHALL return to IDLE and assert o_done for exactly the next cycle; the round counter SHALL not wrap into a 65th word.
- REQ-023 i_start SHALL be ignored in LOAD and RUN; i_wvalid SHALL be ignored outside LOAD.
- REQ-024 i_start in the o_done cycle SHALL be honoured (back-to-back blocks, one idle cycle minimum).
- REQ-025 Sustained throughput SHALL be one W_t per cycle with i_tready held high.

Reset
- REQ-026 i_rst=1 SHALL force IDLE, both counters=0, buffer w[0..15]=0, o_wready=0, o_tvalid=0, o_tdata=0, o_tidx=0, o_busy=0, o_done=0 on the next edge.
- REQ-027 Reset SHALL take priority over all inputs, including mid-LOAD or mid-RUN; the partial block SHALL be discarded and no o_done issued.

Verification
- REQ-028 "abc" block: start, load 0x61626380, 14x 0x00000000, 0x00000018, i_tready=1 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, exactly 64 words, o_done one cycle after W63.
- REQ-029 All-zero block -> 64 words all 0x00000000, o_tidx 0..63 in order.
- REQ-030 Backpressure: i_tready toggled randomly during the "abc" block -> identical W sequence to REQ-028; o_tdata/o_tidx stable whenever o_tvalid=1 and i_tready=0.
- REQ-031 Gapped input: i_wvalid deasserted 3 cycles between words -> only valid words stored; RUN entered one cycle after the 16th word.
- REQ-032 Reset at t=30 of RUN, then a new "abc" block -> no o_done for the aborted block; new block matches REQ-028.
- REQ-033 i_start pulsed during RUN and during LOAD -> no effect; i_start in the o_done cycle -> LOAD entered next cycle.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator.
// Loads one 512-bit block as sixteen 32-bit words, then streams W0..W63 through a
// ready/valid handshake. A 16-entry shift window holds W[t..t+15]; each accepted word
// shifts the window by one and appends the next expanded word.
module sha256_msg_sched (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_wvalid,
  input  logic [31:0] i_wdata,
  output logic        o_wready,
  output logic        o_tvalid,
  output logic [31:0] o_tdata,
  output logic [5:0]  o_tidx,
  input  logic        i_tready,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  load_cnt_q;
  logic [5:0]  round_cnt_q;
  logic [31:0] w_q [16];
  logic        done_q;

  logic        xfer;
  logic [31:0] w_new;

  // Small sigma functions from FIPS 180-4; rotations are fixed rewirings.
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Handshake with the round logic; only meaningful in RUN.
  assign xfer = (state_q == StRun) && i_tready;

  // Next schedule word: window holds W[t..t+15], so this yields W[t+16].
  always_comb begin
    w_new = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];
  end

  // Control FSM, counters, window buffer and done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      load_cnt_q  <= 4'd0;
      round_cnt_q <= 6'd0;
      done_q      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= 32'd0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            state_q    <= StLoad;
            load_cnt_q <= 4'd0;
          end
        end
        StLoad: begin
          if (i_wvalid) begin
            w_q[load_cnt_q] <= i_wdata;
            load_cnt_q      <= load_cnt_q + 4'd1;
            if (load_cnt_q == 4'd15) begin
              state_q     <= StRun;
              round_cnt_q <= 6'd0;
            end
          end
        end
        StRun: begin
          if (xfer) begin
            for (int i = 0; i < 15; i++) begin
              w_q[i] <= w_q[i+1];
            end
            w_q[15] <= w_new;
            if (round_cnt_q == 6'd63) begin
              // Last word accepted: stop here rather than wrapping into a 65th word.
              state_q     <= StIdle;
              round_cnt_q <= 6'd0;
              done_q      <= 1'b1;
            end else begin
              round_cnt_q <= round_cnt_q + 6'd1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs are decoded straight from registers; no input-to-output path.
  always_comb begin
    o_wready = (state_q == StLoad);
    o_tvalid = (state_q == StRun);
    o_busy   = (state_q == StLoad) || (state_q == StRun);
    o_tdata  = w_q[0];
    o_tidx   = round_cnt_q;
    o_done   = done_q;
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: stimulus pushes the reference schedule,
// a negedge monitor pops and compares on every accepted word.
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_wvalid = 1'b0;
  logic [31:0] i_wdata = 32'd0;
  logic        i_tready = 1'b0;
  logic        o_wready;
  logic        o_tvalid;
  logic [31:0] o_tdata;
  logic [5:0]  o_tidx;
  logic        o_busy;
  logic        o_done;

  always #5 clk = ~clk;

  sha256_msg_sched dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_wvalid(i_wvalid),
    .i_wdata (i_wdata),
    .o_wready(o_wready),
    .o_tvalid(o_tvalid),
    .o_tdata (o_tdata),
    .o_tidx  (o_tidx),
    .i_tready(i_tready),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          done_seen = 0;
  int          done_expected = 0;
  int          blk_xfers = 0;
  logic [31:0] msg [16];
  logic [31:0] obs [64];
  bit          hold_ready = 1'b1;
  bit          bp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: textbook FIPS 180-4 expansion over a 64-entry array.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_expected();
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 16; t++) w[t] = msg[t];
    for (int t = 16; t < 64; t++) w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      e.idx  = t[5:0];
      e.data = w[t];
      exp_q.push_back(e);
    end
  endtask

  // Round-logic ready driver, offset from stimulus so both settle before the monitor.
  always @(posedge clk) begin
    #2;
    if (hold_ready) i_tready = 1'b0;
    else if (bp_en) i_tready = 1'($urandom_range(0, 1));
    else i_tready = 1'b1;
  end

  // Monitor: scoreboard compare, stall stability and done-pulse timing.
  bit          prev_stall = 1'b0;
  bit          prev_last = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic [5:0]  prev_idx = 6'd0;

  always @(negedge clk) begin
    exp_t e;
    if (prev_stall && o_tvalid) begin
      check("stall_hold_tdata", o_tdata, prev_data);
      check("stall_hold_tidx", {26'd0, o_tidx}, {26'd0, prev_idx});
    end
    if (prev_last || o_done === 1'b1) check("done_pulse", {31'd0, o_done}, {31'd0, prev_last});
    if (o_done === 1'b1) done_seen++;
    if (o_tvalid === 1'b1 && i_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got tidx=%0d tdata=%h expected no word", o_tidx, o_tdata);
      end else begin
        e = exp_q.pop_front();
        check("tidx", {26'd0, o_tidx}, {26'd0, e.idx});
        check("tdata", o_tdata, e.data);
      end
      obs[o_tidx] = o_tdata;
      blk_xfers++;
    end
    prev_last  = (o_tvalid === 1'b1) && i_tready && (o_tidx == 6'd63);
    prev_stall = (o_tvalid === 1'b1) && !i_tready;
    prev_data  = o_tdata;
    prev_idx   = o_tidx;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wready"}, {31'd0, o_wready}, 32'd0);
    check({tag, "_tvalid"}, {31'd0, o_tvalid}, 32'd0);
    check({tag, "_tdata"}, o_tdata, 32'd0);
    check({tag, "_tidx"}, {26'd0, o_tidx}, 32'd0);
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, o_done}, 32'd0);
  endtask

  // Runs one block from IDLE (or the done cycle). gap: 3 idle cycles between words;
  // poke: i_start during LOAD and i_start/i_wvalid during RUN; abort_at>=0: reset there.
  task automatic send_block(input bit gap, input bit poke, input int abort_at);
    int k;
    blk_xfers = 0;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("load_entry_wready", {31'd0, o_wready}, 32'd1);
    push_expected();
    for (int j = 0; j < 16; j++) begin
      i_wvalid = 1'b1;
      i_wdata  = msg[j];
      if (poke && j == 5) i_start = 1'b1;
      @(posedge clk); #1;
      i_wvalid = 1'b0;
      i_start  = 1'b0;
      if (gap && j < 15) begin
        repeat (3) begin
          i_wdata = $urandom;
          @(posedge clk); #1;
        end
      end
    end
    check("run_entry_tvalid", {31'd0, o_tvalid}, 32'd1);
    check("run_entry_wready", {31'd0, o_wready}, 32'd0);
    if (poke) begin
      i_start  = 1'b1;
      i_wvalid = 1'b1;
      i_wdata  = $urandom;
      repeat (3) @(posedge clk);
      #1;
      i_start  = 1'b0;
      i_wvalid = 1'b0;
      check("run_ignores_start_busy", {31'd0, o_busy}, 32'd1);
    end
    if (abort_at >= 0) begin
      k = 0;
      while (!(o_tvalid && o_tidx == abort_at[5:0]) && k < 400) begin
        @(posedge clk); #1;
        k++;
      end
      check("abort_point_reached", {31'd0, o_tvalid}, 32'd1);
      hold_ready = 1'b1;
      i_rst      = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      i_rst      = 1'b0;
      hold_ready = 1'b0;
      check_reset_outputs("abort_rst");
      repeat (4) @(posedge clk);
      #1;
    end else begin
      k = 0;
      while (o_done !== 1'b1 && k < 2000) begin
        @(posedge clk); #1;
        k++;
      end
      check("done_seen_in_time", {31'd0, o_done}, 32'd1);
      check("idle_after_done", {31'd0, o_tvalid}, 32'd0);
      check("words_per_block", blk_xfers, 64);
      done_expected++;
    end
  endtask

  task automatic set_abc();
    for (int j = 0; j < 16; j++) msg[j] = 32'd0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  task automatic set_random();
    for (int j = 0; j < 16; j++) msg[j] = $urandom;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    i_start  = 1'b1;
    i_wvalid = 1'b1;
    @(posedge clk); #1;
    i_rst      = 1'b0;
    i_start    = 1'b0;
    i_wvalid   = 1'b0;
    check_reset_outputs("reset");
    hold_ready = 1'b0;

    // "abc" block, ready held high; spot-check known schedule words.
    set_abc();
    send_block(1'b0, 1'b0, -1);
    check("abc_w0", obs[0], 32'h61626380);
    check("abc_w15", obs[15], 32'h00000018);
    check("abc_w16", obs[16], 32'h61626380);
    check("abc_w17", obs[17], 32'h000F0000);

    // All-zero block, started in the done cycle of the previous one.
    for (int j = 0; j < 16; j++) msg[j] = 32'd0;
    send_block(1'b0, 1'b0, -1);

    // "abc" under random backpressure.
    bp_en = 1'b1;
    set_abc();
    send_block(1'b0, 1'b0, -1);
    bp_en = 1'b0;

    // Gapped input, then ignored i_start/i_wvalid pokes.
    set_random();
    send_block(1'b1, 1'b0, -1);
    set_random();
    send_block(1'b0, 1'b1, -1);

    // Abort mid-RUN, then a fresh "abc" block.
    set_abc();
    send_block(1'b0, 1'b0, 30);
    set_abc();
    send_block(1'b0, 1'b0, -1);
    check("abc_again_w17", obs[17], 32'h000F0000);

    // Random blocks with backpressure and gaps.
    bp_en = 1'b1;
    for (int b = 0; b < 4; b++) begin
      set_random();
      send_block(b[0], b[1], -1);
    end
    bp_en = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("done_count", done_seen, done_expected);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
